// File: rtl/sr_monitor_if.sv
// sr_monitor_if: groups the observed SR flip-flop signals and the monitor results.
//   s, r, q_obs  - set/reset commands and Q of the monitored flip-flop
//   clear        - synchronous clear of counters and sticky flag
//   q_exp        - expected Q from the reference model
//   synced       - monitor is tracking (expected value known)
//   err_pulse    - one-cycle mismatch indication
//   err_sticky   - latched mismatch flag
//   err_cnt      - saturating mismatch count
//   chk_cnt      - wrapping count of compared cycles
//   illegal      - one-cycle pulse when s=r=1 was sampled
// Modports: master drives stimulus and observes results; slave is the monitor side.
interface sr_monitor_if;
    logic        s;
    logic        r;
    logic        q_obs;
    logic        clear;
    logic        q_exp;
    logic        synced;
    logic        err_pulse;
    logic        err_sticky;
    logic [7:0]  err_cnt;
    logic [15:0] chk_cnt;
    logic        illegal;

    modport master (
        output s, r, q_obs, clear,
        input  q_exp, synced, err_pulse, err_sticky, err_cnt, chk_cnt, illegal
    );

    modport slave (
        input  s, r, q_obs, clear,
        output q_exp, synced, err_pulse, err_sticky, err_cnt, chk_cnt, illegal
    );
endinterface

// File: rtl/sr_monitor.sv
// sr_monitor: checks an SR flip-flop against an internal reference model.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - sr_monitor_if.slave (see interface file for signal list)
// Build option: define SR_MON_ILLEGAL_EN to pulse bus.illegal when s=r=1 is sampled;
// otherwise bus.illegal is tied to 0. The FSM is identical in both builds.
module sr_monitor (
    input logic         clk,
    input logic         rst_n,
    sr_monitor_if.slave bus
);

    typedef enum logic [0:0] {StUnsync, StTrack} state_e;

    state_e      state_q, state_d;
    logic        q_exp_q, q_exp_d;
    logic        err_pulse_q, err_pulse_d;
    logic        err_sticky_q, err_sticky_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [15:0] chk_cnt_q, chk_cnt_d;
    logic        compare;
    logic        mismatch;
    logic        set_cmd, rst_cmd, both_cmd;

    assign set_cmd  = bus.s & ~bus.r;
    assign rst_cmd  = ~bus.s & bus.r;
    assign both_cmd = bus.s & bus.r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StUnsync;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any single command syncs, s=r=1 loses sync
    always_comb begin
        state_d = state_q;
        if (set_cmd || rst_cmd) begin
            state_d = StTrack;
        end else if (both_cmd) begin
            state_d = StUnsync;
        end
    end

    // FSM outputs, decoded from the state flop only
    always_comb begin
        compare    = 1'b0;
        bus.synced = 1'b0;
        unique case (state_q)
            StTrack: begin
                compare    = 1'b1;
                bus.synced = 1'b1;
            end
            default: begin
                compare    = 1'b0;
                bus.synced = 1'b0;
            end
        endcase
    end

    // Compare uses the current model value; a mismatch never reloads it
    assign mismatch = compare & (bus.q_obs != q_exp_q);

    always_comb begin
        q_exp_d      = q_exp_q;
        err_pulse_d  = mismatch;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        chk_cnt_d    = chk_cnt_q;

        if (set_cmd) begin
            q_exp_d = 1'b1;
        end else if (rst_cmd) begin
            q_exp_d = 1'b0;
        end

        // clear takes priority over counting, but err_pulse still reports the mismatch
        if (bus.clear) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = 8'd0;
            chk_cnt_d    = 16'd0;
        end else begin
            if (compare) begin
                chk_cnt_d = chk_cnt_q + 16'd1;
            end
            if (mismatch) begin
                err_sticky_d = 1'b1;
                if (err_cnt_q != 8'hff) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_exp_q      <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= 8'd0;
            chk_cnt_q    <= 16'd0;
        end else begin
            q_exp_q      <= q_exp_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
        end
    end

    assign bus.q_exp      = q_exp_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.chk_cnt    = chk_cnt_q;

`ifdef SR_MON_ILLEGAL_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= both_cmd;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule
